// File: rtl/var_lane_packer_pkg.sv
// Shared types for the variable-lane packer: classifies what leaves the hold buffer each cycle.
package var_lane_packer_pkg;

  typedef enum logic [1:0] {
    EmitNone    = 2'd0,
    EmitFull    = 2'd1,
    EmitPartial = 2'd2
  } emit_e;

endpackage

// File: rtl/var_lane_packer_if.sv
// Lane-request input side plus packed-word output stream of var_lane_packer.
interface var_lane_packer_if #(
  parameter int unsigned ElemWidth = 8,
  parameter int unsigned NumElem   = 4
);
  localparam int unsigned NumW = $clog2(NumElem + 1);
  localparam int unsigned StW  = $clog2(NumElem);
  localparam int unsigned CntW = $clog2(2 * NumElem + 1);

  logic [NumW-1:0]              data_in_num_lanes_i;
  logic [StW-1:0]               data_in_start_lane_i;
  logic                         data_in_req_valid_o;
  logic [NumElem*ElemWidth-1:0] data_in_i;
  logic                         data_in_valid_i;
  logic                         data_in_ready_o;
  logic                         flush_i;
  logic [NumElem*ElemWidth-1:0] word_o;
  logic [NumElem-1:0]           word_keep_o;
  logic                         word_valid_o;
  logic                         word_ready_i;
  logic [CntW-1:0]              count_o;

  modport slave (
    input  data_in_num_lanes_i, data_in_start_lane_i, data_in_i, data_in_valid_i,
           flush_i, word_ready_i,
    output data_in_req_valid_o, data_in_ready_o, word_o, word_keep_o, word_valid_o, count_o
  );

  modport master (
    output data_in_num_lanes_i, data_in_start_lane_i, data_in_i, data_in_valid_i,
           flush_i, word_ready_i,
    input  data_in_req_valid_o, data_in_ready_o, word_o, word_keep_o, word_valid_o, count_o
  );
endinterface

// File: rtl/var_lane_packer_xbar.sv
// Start-lane aligner: output lane j takes input lane start+j; lanes past the top read zero.
module var_lane_packer_xbar #(
  parameter int unsigned ElemWidth = 8,
  parameter int unsigned NumElem   = 4,
  localparam int unsigned StW      = $clog2(NumElem)
) (
  input  logic [StW-1:0]                    start_i,
  input  logic [NumElem-1:0][ElemWidth-1:0] data_i,
  output logic [NumElem-1:0][ElemWidth-1:0] aligned_o
);

  always_comb begin
    aligned_o = '0;
    for (int j = 0; j < NumElem; j++) begin
      for (int k = 0; k < NumElem; k++) begin
        if (int'(start_i) + j == k) aligned_o[j] = data_i[k];
      end
    end
  end

endmodule

// File: rtl/var_lane_packer.sv
// Repacks variable-lane chunks gap-free into full NumElem-wide words, oldest element in lane 0.
// Optional partial-word flush is built when VAR_LANE_PACKER_FLUSH_EN is defined.
module var_lane_packer import var_lane_packer_pkg::*; #(
  parameter int unsigned ElemWidth = 8,
  parameter int unsigned NumElem   = 4
) (
  input logic              clk_i,
  input logic              arst_ni,
  var_lane_packer_if.slave bus
);
  localparam int unsigned Depth = 2 * NumElem;
  localparam int unsigned NumW  = $clog2(NumElem + 1);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned SumW  = NumW + 1;

  logic [Depth-1:0][ElemWidth-1:0]   hold_q, hold_d;
  logic [NumElem-1:0][ElemWidth-1:0] aligned, word;
  logic [NumElem-1:0]                keep;
  logic [CntW-1:0]                   count_q, count_d, emitted, base;
  logic [CntW:0]                     fill;
  logic                              pend_q, pend_d, flush_set;
  logic                              req_valid, in_hs, out_hs, word_valid;
  emit_e                             emit;

  var_lane_packer_xbar #(.ElemWidth(ElemWidth), .NumElem(NumElem)) u_xbar (
    .start_i   (bus.data_in_start_lane_i),
    .data_i    (bus.data_in_i),
    .aligned_o (aligned)
  );

  // Sum is widened so start+num can never wrap before the compare.
  assign req_valid = (SumW'(bus.data_in_start_lane_i) + SumW'(bus.data_in_num_lanes_i))
                     <= SumW'(NumElem);
  assign fill      = {1'b0, count_q} + (CntW+1)'(bus.data_in_num_lanes_i);
  assign word_valid = (count_q >= CntW'(NumElem)) | pend_q;
  assign out_hs    = word_valid & bus.word_ready_i;

`ifdef VAR_LANE_PACKER_FLUSH_EN
  assign flush_set = bus.flush_i & ~pend_q & (count_q != '0) & (count_q < CntW'(NumElem));
  assign pend_d    = flush_set | (pend_q & ~out_hs);
`else
  logic unused_flush;
  assign unused_flush = bus.flush_i;
  assign flush_set    = 1'b0;
  assign pend_d       = 1'b0;
`endif

  // Input is refused while a partial word is being captured, so the flushed word stays frozen.
  assign bus.data_in_ready_o = req_valid & (fill <= (CntW+1)'(Depth)) & ~pend_q & ~flush_set;
  assign in_hs = bus.data_in_valid_i & bus.data_in_ready_o;

  always_comb begin
    emit    = EmitNone;
    emitted = '0;
    if (out_hs) emit = pend_q ? EmitPartial : EmitFull;
    case (emit)
      EmitFull:    emitted = CntW'(NumElem);
      EmitPartial: emitted = count_q;
      default:     emitted = '0;
    endcase
  end

  assign base    = count_q - emitted;
  assign count_d = base + (in_hs ? CntW'(bus.data_in_num_lanes_i) : '0);

  // Shift out the emitted lanes first, then append new lanes at the post-shift count.
  always_comb begin
    hold_d = hold_q >> (emitted * ElemWidth);
    for (int i = 0; i < Depth; i++) begin
      for (int j = 0; j < NumElem; j++) begin
        if (in_hs && (CntW'(j) < CntW'(bus.data_in_num_lanes_i)) && (int'(base) + j == i))
          hold_d[i] = aligned[j];
      end
    end
  end

  always_comb begin
    word = hold_q[NumElem-1:0];
    keep = {NumElem{word_valid}};
`ifdef VAR_LANE_PACKER_FLUSH_EN
    if (pend_q) begin
      for (int j = 0; j < NumElem; j++) begin
        if (CntW'(j) >= count_q) begin
          word[j] = '0;
          keep[j] = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hold_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.data_in_req_valid_o = req_valid;
  assign bus.word_o              = word;
  assign bus.word_keep_o         = keep;
  assign bus.word_valid_o        = word_valid;
  assign bus.count_o             = count_q;

endmodule

// File: tb/tb_var_lane_packer.sv
// Directed bench for var_lane_packer (NumElem=4, ElemWidth=8) with a queue-based output scoreboard.
module tb_var_lane_packer;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  var_lane_packer_if #(.ElemWidth(8), .NumElem(4)) bus ();
  var_lane_packer #(.ElemWidth(8), .NumElem(4)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];  // {keep, word}
  logic [35:0] exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    if (arst_n && bus.word_valid_o && bus.word_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h with nothing expected", bus.word_o);
      end else begin
        exp_e = exp_q.pop_front();
        chk("word", bus.word_o, exp_e[31:0]);
        chk("keep", 32'(bus.word_keep_o), 32'(exp_e[35:32]));
      end
    end
  end

  task automatic send(input logic [1:0] st, input logic [2:0] n, input logic [31:0] d,
                      input logic wr);
    int t;
    @(posedge clk); #1;
    bus.data_in_start_lane_i = st;
    bus.data_in_num_lanes_i  = n;
    bus.data_in_i            = d;
    bus.data_in_valid_i      = 1'b1;
    bus.word_ready_i         = wr;
    t = 0;
    @(negedge clk);
    while (!bus.data_in_ready_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.data_in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready stayed 0 for start=%0d num=%0d", st, n);
    end
    @(posedge clk); #1;
    bus.data_in_valid_i = 1'b0;
  endtask

  initial begin
    int t;
    bus.data_in_num_lanes_i  = '0;
    bus.data_in_start_lane_i = '0;
    bus.data_in_i            = '0;
    bus.data_in_valid_i      = 1'b0;
    bus.flush_i              = 1'b0;
    bus.word_ready_i         = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_valid", 32'(bus.word_valid_o), 0);
    chk("rst_keep", 32'(bus.word_keep_o), 0);
    @(posedge clk); #1 arst_n = 1'b1;

    // Reset mid-stream with three elements held: nothing stale may come out afterwards.
    send(2'd0, 3'd3, 32'h00_33_22_11, 1'b1);
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.count_o), 3);
    arst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(bus.count_o), 0);
    chk("mid_rst_valid", 32'(bus.word_valid_o), 0);
    @(posedge clk); #1 arst_n = 1'b1;

    // {A,B,C} from start 1, then {D,E} from start 0 -> {A,B,C,D}, E left over.
    exp_q.push_back({4'hF, 32'hD0_C0_B0_A0});
    send(2'd1, 3'd3, 32'hC0_B0_A0_EE, 1'b1);
    send(2'd0, 3'd2, 32'hEE_EE_E0_D0, 1'b1);
    repeat (2) @(negedge clk);
    chk("after_word_count", 32'(bus.count_o), 1);
    chk("after_word_valid", 32'(bus.word_valid_o), 0);

    // Illegal lane requests are refused without touching state.
    @(posedge clk); #1;
    bus.data_in_start_lane_i = 2'd3;
    bus.data_in_num_lanes_i  = 3'd2;
    bus.data_in_valid_i      = 1'b1;
    @(negedge clk);
    chk("bad_req_valid", 32'(bus.data_in_req_valid_o), 0);
    chk("bad_ready", 32'(bus.data_in_ready_o), 0);
    @(posedge clk); #1;
    bus.data_in_start_lane_i = 2'd1;
    bus.data_in_num_lanes_i  = 3'd4;
    @(negedge clk);
    chk("bad_req_valid2", 32'(bus.data_in_req_valid_o), 0);
    @(posedge clk); #1;
    bus.data_in_valid_i      = 1'b0;
    bus.data_in_start_lane_i = 2'd2;
    bus.data_in_num_lanes_i  = 3'd2;
    @(negedge clk);
    chk("edge_req_valid", 32'(bus.data_in_req_valid_o), 1);
    chk("bad_req_count", 32'(bus.count_o), 1);

    // num=0 completes the handshake with no state change.
    send(2'd2, 3'd0, 32'h99_99_99_99, 1'b1);
    @(negedge clk);
    chk("num0_count", 32'(bus.count_o), 1);

    exp_q.push_back({4'hF, 32'h13_12_11_E0});
    send(2'd0, 3'd3, 32'h77_13_12_11, 1'b1);
    repeat (2) @(negedge clk);
    chk("drain_count", 32'(bus.count_o), 0);

    // Fill to 8 with the consumer stalled; the third beat waits for one word to drain.
    exp_q.push_back({4'hF, 32'h24_23_22_21});
    exp_q.push_back({4'hF, 32'h34_33_32_31});
    exp_q.push_back({4'hF, 32'h44_43_42_41});
    send(2'd0, 3'd4, 32'h24_23_22_21, 1'b0);
    send(2'd0, 3'd4, 32'h34_33_32_31, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(bus.count_o), 8);
    fork
      send(2'd0, 3'd4, 32'h44_43_42_41, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("full_ready", 32'(bus.data_in_ready_o), 0);
        chk("full_hold_count", 32'(bus.count_o), 8);
        @(posedge clk); #1 bus.word_ready_i = 1'b1;
        @(posedge clk); #1 bus.word_ready_i = 1'b0;
      end
    join
    @(negedge clk);
    chk("refill_count", 32'(bus.count_o), 8);
    @(posedge clk); #1 bus.word_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_drain_count", 32'(bus.count_o), 0);

    // count=5 with output and input handshakes in the same cycle: no bubble.
    exp_q.push_back({4'hF, 32'h53_52_51_50});
    exp_q.push_back({4'hF, 32'h63_62_61_54});
    send(2'd0, 3'd1, 32'h00_00_00_50, 1'b0);
    send(2'd0, 3'd4, 32'h54_53_52_51, 1'b0);
    @(negedge clk);
    chk("c5_count", 32'(bus.count_o), 5);
    send(2'd1, 3'd3, 32'h63_62_61_00, 1'b1);
    @(negedge clk);
    chk("same_cycle_count", 32'(bus.count_o), 4);
    chk("same_cycle_valid", 32'(bus.word_valid_o), 1);
    @(negedge clk);
    chk("same_cycle_drain", 32'(bus.count_o), 0);

`ifdef VAR_LANE_PACKER_FLUSH_EN
    exp_q.push_back({4'h3, 32'h00_00_72_71});
    send(2'd0, 3'd2, 32'hAA_AA_72_71, 1'b0);
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.word_valid_o), 1);
    chk("flush_keep_pre", 32'(bus.word_keep_o), 32'h3);
    chk("flush_ready", 32'(bus.data_in_ready_o), 0);
    @(posedge clk); #1 bus.word_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_count", 32'(bus.count_o), 0);
    chk("flush_valid_after", 32'(bus.word_valid_o), 0);
`else
    bus.flush_i = 1'b1;
    send(2'd0, 3'd2, 32'hAA_AA_72_71, 1'b1);
    repeat (2) @(negedge clk);
    chk("noflush_valid", 32'(bus.word_valid_o), 0);
    chk("noflush_count", 32'(bus.count_o), 2);
    exp_q.push_back({4'hF, 32'h74_73_72_71});
    send(2'd0, 3'd2, 32'hAA_AA_74_73, 1'b1);
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("noflush_drain", 32'(bus.count_o), 0);
`endif

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_left", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
